hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline stall/flush controller; counterpart to the operand bypass logic: detects hazards that bypassing cannot cover.
//  Sits in ID: load-use interlock vs ID/EX, 32-entry scoreboard for multi-cycle (div/long-load) writers, taken-branch flush.
//  Drives PC/IF-ID hold and IF-ID / ID-EX bubble controls; all outputs combinational from current state + inputs.
// PARAMETERS
//  LONG_DEPTH  2  max multi-cycle ops in flight (1..4); issue beyond this stalls
// PORTS
//  clk               in   1  clock; all state updates on rising edge
//  rst               in   1  synchronous, active-high reset
//  id_valid          in   1  ID holds a real instruction
//  id_rs1/id_rs2     in   5  ID source regs
//  id_use_rs1/_rs2   in   1  ID instruction reads rs1/rs2
//  id_rd             in   5  ID destination
//  id_regfile_we     in   1  ID instruction writes rd
//  id_long           in   1  ID instruction is a multi-cycle op (result via lu_done)
//  de_mem_read       in   1  ID/EX instruction is a load
//  de_rd             in   5  ID/EX destination
//  lu_done           in   1  multi-cycle unit writes back this cycle
//  lu_rd             in   5  register written by lu_done
//  ex_branch_taken   in   1  EX resolved taken branch/jump
//  stall_pc          out  1  hold PC
//  stall_fd          out  1  hold IF/ID register
//  flush_fd          out  1  zero IF/ID register
//  flush_de          out  1  insert bubble in ID/EX
//  sb_busy           out  1  any scoreboard bit set
// BEHAVIOUR
//  Reset: pending[31:0]=0, occ=0; outputs then follow comb rules (all 0 for idle inputs).
//  Reg x0 never hazards: pending[0] hard 0; rd==0 never sets, matches, or stalls.
//  clr_mask = lu_done ? onehot(lu_rd) : 0; eff = pending & ~clr_mask (same-cycle writeback releases, regfile write-through).
//  load_use = de_mem_read && de_rd!=0 && ((id_use_rs1&&de_rd==id_rs1)||(id_use_rs2&&de_rd==id_rs2)).
//  raw = (id_use_rs1&&eff[id_rs1]) || (id_use_rs2&&eff[id_rs2]);  waw = id_regfile_we&&eff[id_rd].
//  struct = id_long && occ==LONG_DEPTH && !lu_done.
//  hz = id_valid && (load_use||raw||waw||struct).
//  Priority: ex_branch_taken -> flush_fd=1, flush_de=1, stall_pc=stall_fd=0 (branch kills ID; hazards ignored).
//   else hz -> stall_pc=stall_fd=1, flush_de=1, flush_fd=0.  else all 0.
//  issue = id_valid && id_long && !hz && !ex_branch_taken.
//  Next state: pending <= (pending & ~clr_mask) | (issue&&id_rd!=0 ? onehot(id_rd):0); set wins on same reg.
//  occ <= occ + issue - lu_done; lu_done with occ==0 ignored (occ stays 0, sim assertion fires).
//  Load-use stall lasts exactly 1 cycle (load moves to EX/MEM, bypass covers it).
//  Scoreboard stall lasts until lu_done for that reg; releases in the lu_done cycle itself.
//  sb_busy = |pending (registered state, not eff).
//  Reset mid-stall: next cycle pending/occ=0, stall drops unless load_use present.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cycles[31:0], flush_cycles[31:0]; +1 per cycle stall_pc/flush_fd
//   asserted, saturate at 32'hFFFF_FFFF, clear on rst. Undefined: ports and counters absent; no other change.
// STRUCTURE
//  hazard_pkg: REG_ADDR_W=5, NUM_REGS=32, function onehot32(addr) with x0 masked.
//  Sub-module reg_scoreboard (pending vector, occ counter, eff/read ports); hazard_unit holds comb priority logic.
// TESTING
//  1 load x5 in ID/EX, ID add x6,x5,x1 -> one cycle stall_pc=stall_fd=flush_de=1, then 0.
//  2 issue div x7 (occ 0->1), next ID uses x7; lu_done lu_rd=7 at cycle 4 -> stall cycles 1-3, released cycle 4.
//  3 LONG_DEPTH=2, two divs in flight, third div in ID -> stall until lu_done; with lu_done same cycle -> issues, occ stays 2.
//  4 ex_branch_taken during load-use hazard -> flush_fd=flush_de=1, stall_pc=0; long op in ID not issued (occ unchanged).
//  5 rd/rs = x0 with load in ID/EX de_rd=0 and div to x0 -> no stall, pending stays 0, occ increments.
//  6 rst asserted with pending[9]=1 mid-stall -> next cycle sb_busy=0, stalls cleared; STATS_EN counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the hazard controller.
//   REG_ADDR_W : architectural register address width
//   NUM_REGS   : number of architectural registers
//   onehot32() : register address to one-hot mask; x0 always maps to zero
//                so it can never be marked pending or match a hazard.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m    = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/hazard_unit_reg_scoreboard.sv
// reg_scoreboard: pending-write tracker for multi-cycle (div / long-load) ops.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lu_done, lu_rd    multi-cycle writeback this cycle and its destination
//   issue, issue_rd   a multi-cycle op leaves ID this cycle and its destination
//   rd_a1/a2/a3       lookup addresses (ID rs1, rs2, rd)
//   eff_a1/a2/a3      pending bit of each lookup, with this cycle's writeback
//                     already released (regfile writes through)
//   occ_full          number of multi-cycle ops in flight equals LONG_DEPTH
//   sb_busy           any register pending (registered state only)
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int LONG_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lu_done,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rd_a1,
    input  logic [REG_ADDR_W-1:0] rd_a2,
    input  logic [REG_ADDR_W-1:0] rd_a3,
    output logic                  eff_a1,
    output logic                  eff_a2,
    output logic                  eff_a3,
    output logic                  occ_full,
    output logic                  sb_busy
);

    // Wide enough for LONG_DEPTH up to 4.
    localparam int OCC_W = 3;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [NUM_REGS-1:0] clr_mask, set_mask, eff;
    logic                dec;

    always_comb begin
        clr_mask = lu_done ? onehot32(lu_rd) : '0;
        set_mask = issue ? onehot32(issue_rd) : '0;
        eff      = pending_q & ~clr_mask;
        // Set after clear: a new writer to the register just released stays pending.
        pending_d = eff | set_mask;
        // A stray writeback with nothing in flight must not wrap the counter.
        dec      = lu_done && (occ_q != '0);
        occ_d    = occ_q + OCC_W'(issue) - OCC_W'(dec);
    end

    assign eff_a1   = eff[rd_a1];
    assign eff_a2   = eff[rd_a2];
    assign eff_a3   = eff[rd_a3];
    assign occ_full = (occ_q == OCC_W'(LONG_DEPTH));
    assign sb_busy  = |pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            occ_q     <= '0;
        end else begin
            pending_q <= pending_d;
            occ_q     <= occ_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(lu_done && occ_q == '0));
        end
    end
`endif

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage stall/flush controller for hazards operand bypassing
// cannot cover: load-use against ID/EX, RAW/WAW against in-flight multi-cycle
// results, multi-cycle unit occupancy, and taken-branch flush.
// All outputs are combinational from current state plus inputs.
// Optional feature macro HAZARD_STATS_EN adds saturating stall/flush counters.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_rs1/id_rs2, id_use_rs*   ID sources and whether they are read
//   id_rd, id_regfile_we        ID destination and write enable
//   id_long                     ID instruction is a multi-cycle op
//   de_mem_read, de_rd          ID/EX holds a load and its destination
//   lu_done, lu_rd              multi-cycle writeback this cycle
//   ex_branch_taken             EX resolved a taken branch/jump
//   stall_pc, stall_fd          hold PC and IF/ID
//   flush_fd, flush_de          zero IF/ID, bubble into ID/EX
//   sb_busy                     any scoreboard entry pending
//   stall_cycles, flush_cycles  (HAZARD_STATS_EN only) event counters
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int LONG_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regfile_we,
    input  logic                  id_long,
    input  logic                  de_mem_read,
    input  logic [REG_ADDR_W-1:0] de_rd,
    input  logic                  lu_done,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic                  ex_branch_taken,
    output logic                  stall_pc,
    output logic                  stall_fd,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic                  sb_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles
`endif
);

    logic eff_rs1, eff_rs2, eff_rd, occ_full;
    logic load_use, raw, waw, struct_hz, hz, issue;

    reg_scoreboard #(
        .LONG_DEPTH (LONG_DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .lu_done  (lu_done),
        .lu_rd    (lu_rd),
        .issue    (issue),
        .issue_rd (id_rd),
        .rd_a1    (id_rs1),
        .rd_a2    (id_rs2),
        .rd_a3    (id_rd),
        .eff_a1   (eff_rs1),
        .eff_a2   (eff_rs2),
        .eff_a3   (eff_rd),
        .occ_full (occ_full),
        .sb_busy  (sb_busy)
    );

    always_comb begin
        // x0 loads never interlock; scoreboard x0 is hard zero inside reg_scoreboard.
        load_use  = de_mem_read && (de_rd != '0) &&
                    ((id_use_rs1 && (de_rd == id_rs1)) || (id_use_rs2 && (de_rd == id_rs2)));
        raw       = (id_use_rs1 && eff_rs1) || (id_use_rs2 && eff_rs2);
        waw       = id_regfile_we && eff_rd;
        // A writeback this cycle frees a slot for the op waiting in ID.
        struct_hz = id_long && occ_full && !lu_done;
        hz        = id_valid && (load_use || raw || waw || struct_hz);
        issue     = id_valid && id_long && !hz && !ex_branch_taken;
    end

    always_comb begin
        stall_pc = 1'b0;
        stall_fd = 1'b0;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        if (ex_branch_taken) begin
            // The branch kills whatever is in ID, so its hazards are moot.
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (hz) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_fd && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd, de_rd, lu_rd;
    logic       id_use_rs1, id_use_rs2, id_regfile_we, id_long;
    logic       de_mem_read, lu_done, ex_branch_taken;
    logic       stall_pc, stall_fd, flush_fd, flush_de, sb_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [4:0] v;   // {stall_pc, stall_fd, flush_fd, flush_de, sb_busy}
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    hazard_unit #(.LONG_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regfile_we   (id_regfile_we),
        .id_long         (id_long),
        .de_mem_read     (de_mem_read),
        .de_rd           (de_rd),
        .lu_done         (lu_done),
        .lu_rd           (lu_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall_pc        (stall_pc),
        .stall_fd        (stall_fd),
        .flush_fd        (flush_fd),
        .flush_de        (flush_de),
        .sb_busy         (sb_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({stall_pc, stall_fd, flush_fd, flush_de, sb_busy} !== e.v) begin
                bad++;
                $display("FAIL %s: got pc/fd/ffd/fde/busy=%b required=%b", e.nm,
                         {stall_pc, stall_fd, flush_fd, flush_de, sb_busy}, e.v);
            end
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regfile_we = 0; id_long = 0;
        de_mem_read = 0; de_rd = 0; lu_done = 0; lu_rd = 0; ex_branch_taken = 0;
    endtask

    task automatic id_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic lng);
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regfile_we = 1; id_long = lng;
    endtask

    task automatic done(input logic [4:0] r);
        lu_done = 1; lu_rd = r;
    endtask

    // Issue an expectation for the current inputs, then advance one cycle.
    task automatic cyc(input string nm, input logic [4:0] v);
        exp_t x;
        x.nm = nm; x.v = v;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; idle();
        @(posedge clk); #1;
        cyc("reset", 5'b00000);
`ifdef HAZARD_STATS_EN
        total++;
        if (stall_cycles !== 0 || flush_cycles !== 0) begin
            bad++; $display("FAIL stats_reset: got %0d/%0d required 0/0", stall_cycles, flush_cycles);
        end
`endif
        rst = 0;

        // 1: load-use
        idle(); de_mem_read = 1; de_rd = 5; id_set(5, 1, 1, 1, 6, 0);
        cyc("lu_rs1", 5'b11010);
        idle(); id_set(5, 1, 1, 1, 6, 0);
        cyc("lu_release", 5'b00000);
        idle(); de_mem_read = 1; de_rd = 3; id_set(1, 1, 3, 1, 6, 0);
        cyc("lu_rs2", 5'b11010);
        idle(); de_mem_read = 1; de_rd = 3; id_set(1, 1, 3, 0, 6, 0);
        cyc("lu_rs2_unused", 5'b00000);

        // 2: scoreboard RAW
        idle(); id_set(1, 1, 0, 0, 7, 1);
        cyc("div7_issue", 5'b00000);
        idle(); id_set(7, 1, 0, 0, 8, 0);
        cyc("raw_c1", 5'b11011);
        cyc("raw_c2", 5'b11011);
        cyc("raw_c3", 5'b11011);
        done(7);
        cyc("raw_release", 5'b00001);
        idle();
        cyc("raw_idle", 5'b00000);

        // WAW
        id_set(0, 0, 0, 0, 9, 1);
        cyc("div9_issue", 5'b00000);
        id_set(0, 0, 0, 0, 9, 0);
        cyc("waw_stall", 5'b11011);
        done(9);
        cyc("waw_release", 5'b00001);
        idle();
        cyc("waw_idle", 5'b00000);

        // 3: structural
        id_set(0, 0, 0, 0, 10, 1);
        cyc("div10", 5'b00000);
        id_set(0, 0, 0, 0, 11, 1);
        cyc("div11", 5'b00001);
        id_set(0, 0, 0, 0, 12, 1);
        cyc("struct_c1", 5'b11011);
        cyc("struct_c2", 5'b11011);
        done(10);
        cyc("struct_issue_on_done", 5'b00001);
        idle(); id_set(0, 0, 0, 0, 13, 1);
        cyc("struct_occ_still2", 5'b11011);
        idle(); done(11);
        cyc("drain11", 5'b00001);
        done(12);
        cyc("drain12", 5'b00001);
        idle();
        cyc("drain_idle", 5'b00000);

        // 4: branch wins over load-use; long op not issued
        de_mem_read = 1; de_rd = 5; ex_branch_taken = 1; id_set(5, 1, 0, 0, 14, 1);
        cyc("branch_flush", 5'b00110);
        idle();
        cyc("branch_no_issue", 5'b00000);

        // 5: x0 never hazards
        de_mem_read = 1; de_rd = 0; id_set(0, 1, 0, 1, 0, 1);
        cyc("x0_no_stall", 5'b00000);
        idle();
        cyc("x0_not_pending", 5'b00000);
        id_set(0, 0, 0, 0, 15, 1);
        cyc("div15", 5'b00000);
        id_set(0, 0, 0, 0, 16, 1);
        cyc("x0_counted_struct", 5'b11011);
        done(0);
        cyc("x0_done_issue16", 5'b00001);
        idle(); done(15);
        cyc("drain15", 5'b00001);
        done(16);
        cyc("drain16", 5'b00001);
        idle();
        cyc("drain5_idle", 5'b00000);

        // 6: reset mid-stall
        id_set(0, 0, 0, 0, 9, 1);
        cyc("div9b", 5'b00000);
        idle(); id_set(9, 1, 0, 0, 17, 0);
        cyc("sb9_stall", 5'b11011);
        rst = 1;
        cyc("rst_cycle", 5'b11011);
        rst = 0;
        cyc("post_rst", 5'b00000);
`ifdef HAZARD_STATS_EN
        total++;
        if (stall_cycles !== 0 || flush_cycles !== 0) begin
            bad++; $display("FAIL stats_after_rst: got %0d/%0d required 0/0", stall_cycles, flush_cycles);
        end
`endif
        idle(); id_set(0, 0, 0, 0, 20, 1);
        cyc("occ0_div20", 5'b00000);
        id_set(0, 0, 0, 0, 21, 1);
        cyc("occ0_div21", 5'b00001);
        id_set(0, 0, 0, 0, 22, 1);
        cyc("occ0_struct", 5'b11011);
        idle(); done(20);
        cyc("drain20", 5'b00001);
        done(21);
        cyc("drain21", 5'b00001);
        idle();
        cyc("final_idle", 5'b00000);

        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
